// File: rtl/rgmii_pkg.sv
// Shared types and constants for the RGMII receive path.
package rgmii_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } rx_state_e;

  localparam logic [7:0] PREAMBLE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE      = 8'hD5;
  localparam logic [3:0] PRE_NIB       = 4'h5;
  localparam logic [3:0] SFD_NIB       = 4'hD;

  localparam logic [1:0] SPD_10   = 2'b00;
  localparam logic [1:0] SPD_100  = 2'b01;
  localparam logic [1:0] SPD_1000 = 2'b10;

  // The in-band speed field carries one reserved encoding that must never be latched.
  function automatic logic speed_code_ok(input logic [1:0] code);
    return (code == SPD_10) || (code == SPD_100) || (code == SPD_1000);
  endfunction

endpackage

// File: rtl/rgmii_rx_if.sv
// Received-byte stream from the RGMII decoder towards the MAC receive FIFO.
interface rgmii_rx_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_sof;
  logic       rx_eof;
  logic       rx_err;

  modport master (output rx_data, rx_valid, rx_sof, rx_eof, rx_err);
  modport slave  (input  rx_data, rx_valid, rx_sof, rx_eof, rx_err);
endinterface

// File: rtl/rgmii_inband_status.sv
// RGMII in-band link status: gated sampling, consecutive-sample filter and status registers.
module rgmii_inband_status
  import rgmii_pkg::*;
#(
  parameter int STATUS_FILTER = 4
) (
  input  logic       user_clk,
  input  logic       reset,
  input  logic       sample_en,
  input  logic [3:0] rxd,
  output logic       link_up,
  output logic [1:0] link_speed,
  output logic       full_duplex
);

  localparam int CW = $clog2(STATUS_FILTER + 1);

  logic [3:0]    cand_r, cand_s;
  logic          cand_ok_r, cand_ok_s;
  logic [CW-1:0] cnt_r, cnt_s;
  logic [3:0]    status_r, status_s;

  // filter next-state: count identical samples, restart on any change
  always_comb begin
    cand_s    = cand_r;
    cand_ok_s = cand_ok_r;
    cnt_s     = cnt_r;
    status_s  = status_r;
    if (!sample_en) begin
      cnt_s = cnt_r;
    end else if (!speed_code_ok(rxd[2:1])) begin
      cand_ok_s = 1'b0;
      cnt_s     = {CW{1'b0}};
    end else if (cand_ok_r && (rxd == cand_r)) begin
      if (cnt_r < CW'(STATUS_FILTER)) begin
        cnt_s = cnt_r + CW'(1);
      end else begin
        cnt_s = cnt_r;
      end
      if (cnt_r >= CW'(STATUS_FILTER - 1)) begin
        status_s = rxd;
      end else begin
        status_s = status_r;
      end
    end else begin
      cand_s    = rxd;
      cand_ok_s = 1'b1;
      cnt_s     = CW'(1);
      if (CW'(1) >= CW'(STATUS_FILTER)) begin
        status_s = rxd;
      end else begin
        status_s = status_r;
      end
    end
  end

  // filter and status registers
  always_ff @(posedge user_clk) begin
    if (reset) begin
      cand_r    <= 4'h0;
      cand_ok_r <= 1'b0;
      cnt_r     <= {CW{1'b0}};
      status_r  <= 4'h0;
    end else begin
      cand_r    <= cand_s;
      cand_ok_r <= cand_ok_s;
      cnt_r     <= cnt_s;
      status_r  <= status_s;
    end
  end

  assign link_up     = status_r[0];
  assign link_speed  = status_r[2:1];
  assign full_duplex = status_r[3];

endmodule

// File: rtl/rgmii_rx.sv
// RGMII receive frame decoder: byte rebuild (DDR/SDR), preamble/SFD strip, frame error flagging.
// In-band status decode is built only when RGMII_RX_INBAND_EN is defined.
module rgmii_rx
  import rgmii_pkg::*;
#(
  parameter int STATUS_FILTER = 4
) (
  input  logic        user_clk,
  input  logic        reset,
  input  logic        speed,
  input  logic [3:0]  rxd_r,
  input  logic [3:0]  rxd_f,
  input  logic        rxctl_r,
  input  logic        rxctl_f,
  rgmii_rx_if.master  rx,
  output logic        link_up,
  output logic [1:0]  link_speed,
  output logic        full_duplex
);

  logic       dv_s, er_s;
  logic [7:0] byte_s;

  rx_state_e  state_r, state_s;
  logic       gig_r, gig_s;
  logic       seen_r, seen_s;
  logic       phase_r, phase_s;
  logic [3:0] low_r, low_s;
  logic       first_r, first_s;
  logic       sticky_r, sticky_s;
  logic [7:0] data_r, data_s;
  logic       valid_r, valid_s;
  logic       sof_r, sof_s;
  logic       eof_r, eof_s;
  logic       err_r, err_s;

  assign dv_s   = rxctl_r;
  assign er_s   = rxctl_r ^ rxctl_f;
  assign byte_s = {rxd_f, rxd_r};

  // next-state and registered-output values; pulses default low every cycle
  always_comb begin
    state_s  = state_r;
    gig_s    = gig_r;
    seen_s   = seen_r;
    phase_s  = phase_r;
    low_s    = low_r;
    first_s  = first_r;
    sticky_s = sticky_r;
    data_s   = data_r;
    valid_s  = 1'b0;
    sof_s    = 1'b0;
    eof_s    = 1'b0;
    err_s    = 1'b0;
    case (state_r)
      IDLE: begin
        sticky_s = 1'b0;
        first_s  = 1'b1;
        seen_s   = 1'b0;
        phase_s  = 1'b0;
        if (dv_s) begin
          state_s = PRE;
          gig_s   = speed;
        end else begin
          state_s = IDLE;
        end
      end
      PRE: begin
        if (!dv_s) begin
          state_s = IDLE;
        end else if (er_s) begin
          state_s = DROP;
        end else if (gig_r) begin
          if (byte_s == PREAMBLE_BYTE) begin
            state_s = PRE;
          end else if (byte_s == SFD_BYTE) begin
            state_s = DATA;
          end else begin
            state_s = DROP;
          end
        end else begin
          if (rxd_r == PRE_NIB) begin
            seen_s = 1'b1;
          end else if ((rxd_r == SFD_NIB) && seen_r) begin
            state_s = DATA;
            phase_s = 1'b0;
          end else begin
            state_s = DROP;
          end
        end
      end
      DATA: begin
        if (!dv_s) begin
          state_s = IDLE;
          eof_s   = 1'b1;
          err_s   = sticky_r | (~gig_r & phase_r);
        end else begin
          if (er_s) begin
            sticky_s = 1'b1;
          end else begin
            sticky_s = sticky_r;
          end
          // SDR mode: the low nibble arrives first, the byte completes on phase 1
          if (gig_r) begin
            data_s  = byte_s;
            valid_s = 1'b1;
            sof_s   = first_r;
            first_s = 1'b0;
          end else if (!phase_r) begin
            low_s   = rxd_r;
            phase_s = 1'b1;
          end else begin
            data_s  = {rxd_r, low_r};
            valid_s = 1'b1;
            sof_s   = first_r;
            first_s = 1'b0;
            phase_s = 1'b0;
          end
        end
      end
      DROP: begin
        if (!dv_s) begin
          state_s = IDLE;
        end else begin
          state_s = DROP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state, datapath and output registers
  always_ff @(posedge user_clk) begin
    if (reset) begin
      state_r  <= IDLE;
      gig_r    <= 1'b0;
      seen_r   <= 1'b0;
      phase_r  <= 1'b0;
      low_r    <= 4'h0;
      first_r  <= 1'b1;
      sticky_r <= 1'b0;
      data_r   <= 8'h00;
      valid_r  <= 1'b0;
      sof_r    <= 1'b0;
      eof_r    <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_s;
      gig_r    <= gig_s;
      seen_r   <= seen_s;
      phase_r  <= phase_s;
      low_r    <= low_s;
      first_r  <= first_s;
      sticky_r <= sticky_s;
      data_r   <= data_s;
      valid_r  <= valid_s;
      sof_r    <= sof_s;
      eof_r    <= eof_s;
      err_r    <= err_s;
    end
  end

  assign rx.rx_data  = data_r;
  assign rx.rx_valid = valid_r;
  assign rx.rx_sof   = sof_r;
  assign rx.rx_eof   = eof_r;
  assign rx.rx_err   = err_r;

`ifdef RGMII_RX_INBAND_EN
  logic sample_en_s;

  // status is only meaningful between frames with no carrier event on the line
  assign sample_en_s = (state_r == IDLE) && !dv_s && !er_s;

  rgmii_inband_status #(
    .STATUS_FILTER (STATUS_FILTER)
  ) u_inband (
    .user_clk    (user_clk),
    .reset       (reset),
    .sample_en   (sample_en_s),
    .rxd         (rxd_r),
    .link_up     (link_up),
    .link_speed  (link_speed),
    .full_duplex (full_duplex)
  );
`else
  assign link_up     = 1'b0;
  assign link_speed  = 2'b00;
  assign full_duplex = 1'b0;
`endif

endmodule

// File: tb/tb_rgmii_rx.sv
// Directed bench for rgmii_rx: expected bytes/eofs are queued as stimulus is driven, compared as they appear.
module tb_rgmii_rx;

  logic       user_clk = 1'b0;
  logic       reset    = 1'b1;
  logic       speed    = 1'b1;
  logic [3:0] rxd_r    = 4'h0;
  logic [3:0] rxd_f    = 4'h0;
  logic       rxctl_r  = 1'b0;
  logic       rxctl_f  = 1'b0;
  logic       link_up;
  logic [1:0] link_speed;
  logic       full_duplex;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       eof;
    logic       sof;
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t q[$];

  rgmii_rx_if rx_bus ();

  rgmii_rx #(.STATUS_FILTER(4)) dut (
    .user_clk    (user_clk),
    .reset       (reset),
    .speed       (speed),
    .rxd_r       (rxd_r),
    .rxd_f       (rxd_f),
    .rxctl_r     (rxctl_r),
    .rxctl_f     (rxctl_f),
    .rx          (rx_bus),
    .link_up     (link_up),
    .link_speed  (link_speed),
    .full_duplex (full_duplex)
  );

  always #4 user_clk = ~user_clk;

  function automatic logic [15:0] all_out();
    return {rx_bus.rx_data, rx_bus.rx_valid, rx_bus.rx_sof, rx_bus.rx_eof, rx_bus.rx_err,
            link_up, link_speed, full_duplex};
  endfunction

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s got=%h want=%h", tag, obs, want);
    end
  endtask

  task automatic check_out();
    exp_t e;
    logic [11:0] obs;
    logic [11:0] want;
    if (rx_bus.rx_valid || rx_bus.rx_eof) begin
      total++;
      assert (q.size() > 0) else begin
        bad++;
        $error("FAIL unexpected_output got valid=%0b eof=%0b data=%h want none",
               rx_bus.rx_valid, rx_bus.rx_eof, rx_bus.rx_data);
      end
      if (q.size() > 0) begin
        e    = q.pop_front();
        obs  = {rx_bus.rx_valid, rx_bus.rx_eof, rx_bus.rx_sof, rx_bus.rx_err,
                rx_bus.rx_valid ? rx_bus.rx_data : 8'h00};
        want = {~e.eof, e.eof, e.sof, e.err, e.eof ? 8'h00 : e.data};
        total++;
        assert (obs === want) else begin
          bad++;
          $error("FAIL stream got={v,e,s,err,data}=%h want=%h", obs, want);
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge user_clk);
    #1;
    check_out();
  endtask

  task automatic drive(input logic dv, input logic er, input logic [7:0] b);
    rxctl_r = dv;
    rxctl_f = dv ^ er;
    rxd_r   = b[3:0];
    rxd_f   = b[7:4];
    cyc();
  endtask

  task automatic push_byte(input logic [7:0] b, input logic sof);
    q.push_back('{eof: 1'b0, sof: sof, err: 1'b0, data: b});
  endtask

  task automatic push_eof(input logic err);
    q.push_back('{eof: 1'b1, sof: 1'b0, err: err, data: 8'h00});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00);
  endtask

  task automatic gig_pre();
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hD5);
  endtask

  task automatic nib_pre();
    for (int i = 0; i < 15; i++) drive(1'b1, 1'b0, 8'h05);
    drive(1'b1, 1'b0, 8'h0D);
  endtask

  task automatic drained(input string tag);
    check_eq(tag, 16'(q.size()), 16'h0000);
  endtask

  logic [3:0] stat_want;

  initial begin
    // reset state
    reset = 1'b1;
    idle(2);
    check_eq("reset_state", all_out(), 16'h0000);
    reset = 1'b0;
    idle(3);

    // 1) 1000M, 64-byte frame
    speed = 1'b1;
    gig_pre();
    for (int i = 0; i < 64; i++) begin
      push_byte(8'(i), i == 0);
      drive(1'b1, 1'b0, 8'(i));
    end
    push_eof(1'b0);
    idle(3);
    drained("t1_gig_frame");

    // 2) 100M nibble frames: even then odd nibble count
    speed = 1'b0;
    idle(1);
    nib_pre();
    drive(1'b1, 1'b0, 8'h01);
    push_byte(8'hA1, 1'b1);
    drive(1'b1, 1'b0, 8'h0A);
    drive(1'b1, 1'b0, 8'h02);
    push_byte(8'hB2, 1'b0);
    drive(1'b1, 1'b0, 8'h0B);
    push_eof(1'b0);
    idle(3);
    drained("t2_sdr_even");

    nib_pre();
    drive(1'b1, 1'b0, 8'h01);
    push_byte(8'hA1, 1'b1);
    drive(1'b1, 1'b0, 8'h0A);
    drive(1'b1, 1'b0, 8'h02);
    push_byte(8'hB2, 1'b0);
    drive(1'b1, 1'b0, 8'h0B);
    drive(1'b1, 1'b0, 8'h03);
    push_eof(1'b1);
    idle(3);
    drained("t2_sdr_odd");

    // 3) mid-frame er, one-cycle gap, then clean frame with a speed change ignored
    speed = 1'b1;
    gig_pre();
    for (int i = 0; i < 8; i++) begin
      push_byte(8'h10 + 8'(i), i == 0);
      drive(1'b1, i == 3, 8'h10 + 8'(i));
    end
    push_eof(1'b1);
    idle(1);
    gig_pre();
    speed = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_byte(8'h20 + 8'(i), i == 0);
      drive(1'b1, 1'b0, 8'h20 + 8'(i));
    end
    push_eof(1'b0);
    idle(3);
    drained("t3_err_then_clean");
    speed = 1'b1;

    // 4) bad preamble is dropped quietly, next frame decodes
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'h55);
    drive(1'b1, 1'b0, 8'hAA);
    drive(1'b1, 1'b0, 8'hD5);
    drive(1'b1, 1'b0, 8'h01);
    drive(1'b1, 1'b0, 8'h02);
    idle(2);
    drained("t4_drop_quiet");
    gig_pre();
    push_byte(8'h30, 1'b1);
    drive(1'b1, 1'b0, 8'h30);
    push_byte(8'h31, 1'b0);
    drive(1'b1, 1'b0, 8'h31);
    push_eof(1'b0);
    idle(3);
    drained("t4_after_drop");

    // 5) in-band status filter
`ifdef RGMII_RX_INBAND_EN
    stat_want = 4'hD;
`else
    stat_want = 4'h0;
`endif
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'h0D);
      check_eq("status_hold", {12'h000, link_up, link_speed, full_duplex}, 16'h0000);
    end
    drive(1'b0, 1'b0, 8'h0D);
    check_eq("status_update", {12'h000, link_up, link_speed, full_duplex}, {12'h000, stat_want});
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b0, 8'h07);
    check_eq("status_code11", {12'h000, link_up, link_speed, full_duplex}, {12'h000, stat_want});

    // reset mid-frame
    gig_pre();
    push_byte(8'h00, 1'b1);
    drive(1'b1, 1'b0, 8'h00);
    push_byte(8'h01, 1'b0);
    drive(1'b1, 1'b0, 8'h01);
    reset = 1'b1;
    drive(1'b1, 1'b0, 8'h02);
    check_eq("reset_midframe", all_out(), 16'h0000);
    reset = 1'b0;
    idle(3);
    drained("final_drained");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
